vx_cache_core_rsp_gather: RTL and testbench

Merges per-bank cache read responses into whole-warp core responses, sitting between the cache banks and the core response port. Valid banks whose tag ID matches are combined into one multi-lane response. The winning bank is chosen round-robin. Merged responses are held in a parametrised output FIFO. All bank-side readies are registered-state-driven, with no combinational path from `core_rsp_ready`.

---
 rtl/vx_cache_core_rsp_gather.sv | 170 +++++++++++++++++
 tb/tb_vx_cache_core_rsp_gather.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_cache_core_rsp_gather.sv
// Merges per-bank cache read responses with matching tag IDs into whole-warp core
// responses. The winner bank is chosen round-robin and results are queued in a small FIFO.
module vx_cache_core_rsp_gather #(
  parameter int NUM_BANKS        = 4,
  parameter int NUM_PORTS        = 1,
  parameter int NUM_REQS         = 4,
  parameter int WORD_SIZE        = 4,
  parameter int CORE_TAG_WIDTH   = 8,
  parameter int CORE_TAG_ID_BITS = 4,
  parameter int OUT_DEPTH        = 2,
  localparam int REQS_BITS       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int WORD_WIDTH      = 8 * WORD_SIZE
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_BANKS-1:0]                          per_bank_core_rsp_valid,
  input  logic [NUM_BANKS*NUM_PORTS-1:0]                per_bank_core_rsp_pmask,
  input  logic [NUM_BANKS*NUM_PORTS*REQS_BITS-1:0]      per_bank_core_rsp_tid,
  input  logic [NUM_BANKS*NUM_PORTS*WORD_WIDTH-1:0]     per_bank_core_rsp_data,
  input  logic [NUM_BANKS*CORE_TAG_WIDTH-1:0]           per_bank_core_rsp_tag,
  output logic [NUM_BANKS-1:0]                          per_bank_core_rsp_ready,
  output logic                                          core_rsp_valid,
  output logic [NUM_REQS-1:0]                           core_rsp_tmask,
  output logic [CORE_TAG_WIDTH-1:0]                     core_rsp_tag,
  output logic [NUM_REQS*WORD_WIDTH-1:0]                core_rsp_data,
  input  logic                                          core_rsp_ready
);

  localparam int RR_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W   = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(OUT_DEPTH - 1);
  localparam logic [RR_BITS-1:0] RR_LAST  = RR_BITS'(NUM_BANKS - 1);

  logic [RR_BITS-1:0]             rr_ptr_r;
  logic [RR_BITS-1:0]             winner_s;
  logic                           found_s;
  logic [NUM_BANKS-1:0]           match_s;
  logic [CORE_TAG_WIDTH-1:0]      win_tag_s;
  logic [NUM_REQS-1:0]            tmask_s;
  logic [NUM_REQS*WORD_WIDTH-1:0] data_s;
  logic [REQS_BITS-1:0]           lane_s;
  logic                           fire_s;
  logic                           pop_s;
  logic [CNT_W-1:0]               count_r;
  logic [PTR_W-1:0]               wr_ptr_r;
  logic [PTR_W-1:0]               rd_ptr_r;

  logic [NUM_REQS-1:0]            mem_tmask_r [OUT_DEPTH];
  logic [CORE_TAG_WIDTH-1:0]      mem_tag_r   [OUT_DEPTH];
  logic [NUM_REQS*WORD_WIDTH-1:0] mem_data_r  [OUT_DEPTH];

  // Winner: first valid bank scanning circularly upward from rr_ptr
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (!found_s && per_bank_core_rsp_valid[(int'(rr_ptr_r) + k) % NUM_BANKS]) begin
        winner_s = RR_BITS'((int'(rr_ptr_r) + k) % NUM_BANKS);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign win_tag_s = per_bank_core_rsp_tag[int'(winner_s)*CORE_TAG_WIDTH +: CORE_TAG_WIDTH];

  generate
    if (CORE_TAG_ID_BITS > 0) begin : g_id_merge
      // Match set: every valid bank sharing the winner's tag ID
      always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
          match_s[i] = per_bank_core_rsp_valid[i] &&
                       (per_bank_core_rsp_tag[i*CORE_TAG_WIDTH +: CORE_TAG_ID_BITS] ==
                        win_tag_s[CORE_TAG_ID_BITS-1:0]);
        end
      end
    end else begin : g_no_merge
      // Match set: the winner bank alone
      always_comb begin
        match_s = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
          match_s[i] = per_bank_core_rsp_valid[i] && (RR_BITS'(i) == winner_s);
        end
      end
    end
  endgenerate

  // Lane assembly; later (bank, port) pairs overwrite earlier ones on a collision
  always_comb begin
    tmask_s = '0;
    data_s  = '0;
    lane_s  = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (match_s[i] && per_bank_core_rsp_pmask[i*NUM_PORTS + p]) begin
          lane_s = per_bank_core_rsp_tid[(i*NUM_PORTS + p)*REQS_BITS +: REQS_BITS];
          if (int'(lane_s) < NUM_REQS) begin
            tmask_s[lane_s] = 1'b1;
            data_s[int'(lane_s)*WORD_WIDTH +: WORD_WIDTH] =
              per_bank_core_rsp_data[(i*NUM_PORTS + p)*WORD_WIDTH +: WORD_WIDTH];
          end else begin
            tmask_s = tmask_s;
          end
        end else begin
          tmask_s = tmask_s;
        end
      end
    end
  end

  // Fire only from registered occupancy; no bypass when full
  assign fire_s = (|per_bank_core_rsp_valid) && (count_r < DEPTH_C) && reset;

  // Bank readies: consume the whole match set on fire
  always_comb begin
    if (fire_s) begin
      per_bank_core_rsp_ready = match_s;
    end else begin
      per_bank_core_rsp_ready = '0;
    end
  end

  assign core_rsp_valid = reset && (count_r != '0);
  assign pop_s          = core_rsp_valid && core_rsp_ready;
  assign core_rsp_tmask = mem_tmask_r[rd_ptr_r];
  assign core_rsp_tag   = mem_tag_r[rd_ptr_r];
  assign core_rsp_data  = mem_data_r[rd_ptr_r];

  // Control state: occupancy, FIFO pointers and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rr_ptr_r <= '0;
    end else begin
      if (fire_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + PTR_W'(1);
        rr_ptr_r <= (winner_s == RR_LAST) ? '0 : winner_s + RR_BITS'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rr_ptr_r <= rr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({fire_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents survive reset, only pointers are cleared
  always_ff @(posedge clk) begin
    if (fire_s) begin
      mem_tmask_r[wr_ptr_r] <= tmask_s;
      mem_tag_r[wr_ptr_r]   <= win_tag_s;
      mem_data_r[wr_ptr_r]  <= data_s;
    end
  end

endmodule

// File: tb/tb_vx_cache_core_rsp_gather.sv
// Directed bench for vx_cache_core_rsp_gather: merge, round-robin, backpressure,
// push/pop, reset and the no-merge (ID_BITS=0) configuration.
module tb_vx_cache_core_rsp_gather;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   valid;
  logic [3:0]   pmask;
  logic [7:0]   tid;
  logic [127:0] data_in;
  logic [31:0]  tag_in;
  logic         core_ready;

  logic [3:0]   ready0, ready1;
  logic         cv0, cv1;
  logic [3:0]   tmask0, tmask1;
  logic [7:0]   tag0, tag1;
  logic [127:0] data0, data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_cache_core_rsp_gather dut (
    .clk(clk), .reset(reset),
    .per_bank_core_rsp_valid(valid), .per_bank_core_rsp_pmask(pmask),
    .per_bank_core_rsp_tid(tid), .per_bank_core_rsp_data(data_in),
    .per_bank_core_rsp_tag(tag_in), .per_bank_core_rsp_ready(ready0),
    .core_rsp_valid(cv0), .core_rsp_tmask(tmask0), .core_rsp_tag(tag0),
    .core_rsp_data(data0), .core_rsp_ready(core_ready)
  );

  vx_cache_core_rsp_gather #(.CORE_TAG_ID_BITS(0)) u1 (
    .clk(clk), .reset(reset),
    .per_bank_core_rsp_valid(valid), .per_bank_core_rsp_pmask(pmask),
    .per_bank_core_rsp_tid(tid), .per_bank_core_rsp_data(data_in),
    .per_bank_core_rsp_tag(tag_in), .per_bank_core_rsp_ready(ready1),
    .core_rsp_valid(cv1), .core_rsp_tmask(tmask1), .core_rsp_tag(tag1),
    .core_rsp_data(data1), .core_rsp_ready(core_ready)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_bank(input int b, input logic v, input logic [7:0] t,
                          input logic [1:0] lane, input logic [31:0] d);
    valid[b]          = v;
    pmask[b]          = 1'b1;
    tid[b*2 +: 2]     = lane;
    data_in[b*32 +: 32] = d;
    tag_in[b*8 +: 8]  = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    reset = 1'b0; valid = 4'b0000; pmask = 4'b0000; tid = 8'h00;
    data_in = 128'h0; tag_in = 32'h0; core_ready = 1'b0;

    // reset state, including a valid bank presented during reset
    tick(); tick();
    set_bank(0, 1'b1, 8'h01, 2'd0, 32'h1);
    #1;
    chk("rst_valid", 128'(cv0), 128'h0);
    chk("rst_ready", 128'(ready0), 128'h0);
    chk("rst_count", 128'(dut.count_r), 128'h0);
    valid = 4'b0000;
    reset = 1'b1;
    core_ready = 1'b1;

    // round-robin: all banks valid with distinct IDs, held
    for (int k = 0; k < 4; k++) begin
      set_bank(k, 1'b1, 8'(k*17 + 1), 2'(k), 32'h1000_0000 + 32'(k));
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = 4'b0001 << k;
      chk("rr_ready", 128'(ready0), 128'(exp_rdy));
      tick();
      chk("rr_head_tag", 128'(tag0), 128'(8'(k*17 + 1)));
      chk("rr_ptr", 128'(dut.rr_ptr_r), 128'((k + 1) % 4));
      chk("rr_count", 128'(dut.count_r), 128'h1);
    end
    valid = 4'b0000;
    tick();
    chk("rr_drain_valid", 128'(cv0), 128'h0);

    // basic merge: banks 0 and 2 share ID 3, bank 1 differs
    set_bank(0, 1'b1, 8'h13, 2'd0, 32'hAAAA0001);
    set_bank(2, 1'b1, 8'h13, 2'd2, 32'hBBBB0002);
    set_bank(1, 1'b1, 8'h25, 2'd1, 32'hCCCC0003);
    #1;
    chk("merge_ready", 128'(ready0), 128'h5);
    tick();
    valid[0] = 1'b0; valid[2] = 1'b0;
    chk("merge_valid", 128'(cv0), 128'h1);
    chk("merge_tmask", 128'(tmask0), 128'h5);
    chk("merge_tag", 128'(tag0), 128'h13);
    chk("merge_data", data0, 128'h00000000_BBBB0002_00000000_AAAA0001);
    #1;
    chk("merge_ready_b1", 128'(ready0), 128'h2);
    tick();
    valid[1] = 1'b0;
    chk("b1_tmask", 128'(tmask0), 128'h2);
    chk("b1_tag", 128'(tag0), 128'h25);
    chk("b1_data", data0, 128'h00000000_00000000_CCCC0003_00000000);
    chk("b1_rr", 128'(dut.rr_ptr_r), 128'h2);
    tick();
    chk("merge_drain", 128'(cv0), 128'h0);

    // full / backpressure with rr_ptr=2
    core_ready = 1'b0;
    set_bank(0, 1'b1, 8'h41, 2'd0, 32'h4100_0000);
    set_bank(1, 1'b1, 8'h52, 2'd1, 32'h5200_0000);
    set_bank(2, 1'b1, 8'h63, 2'd2, 32'h6300_0000);
    #1;
    chk("full_rdy1", 128'(ready0), 128'h4);
    tick();
    valid[2] = 1'b0;
    #1;
    chk("full_rdy2", 128'(ready0), 128'h1);
    tick();
    valid[0] = 1'b0;
    #1;
    chk("full_count", 128'(dut.count_r), 128'h2);
    chk("full_ready0", 128'(ready0), 128'h0);
    chk("full_head", 128'(tag0), 128'h63);
    tick();
    chk("full_hold", 128'(dut.count_r), 128'h2);
    core_ready = 1'b1;
    #1;
    chk("full_no_bypass", 128'(ready0), 128'h0);
    tick();
    core_ready = 1'b0;
    #1;
    chk("after_pop_count", 128'(dut.count_r), 128'h1);
    chk("after_pop_head", 128'(tag0), 128'h41);
    chk("after_pop_ready", 128'(ready0), 128'h2);
    tick();
    valid[1] = 1'b0;
    chk("third_fire_count", 128'(dut.count_r), 128'h2);
    chk("third_fire_head", 128'(tag0), 128'h41);

    // simultaneous push and pop with one entry queued
    core_ready = 1'b1;
    tick();
    chk("pp_pre_count", 128'(dut.count_r), 128'h1);
    chk("pp_pre_head", 128'(tag0), 128'h52);
    set_bank(3, 1'b1, 8'h74, 2'd3, 32'hDDDD0004);
    #1;
    chk("pp_ready", 128'(ready0), 128'h8);
    tick();
    valid[3] = 1'b0;
    chk("pp_count", 128'(dut.count_r), 128'h1);
    chk("pp_head_tag", 128'(tag0), 128'h74);
    chk("pp_head_tmask", 128'(tmask0), 128'h8);
    chk("pp_head_data", data0, 128'hDDDD0004_00000000_00000000_00000000);
    tick();
    chk("pp_drain", 128'(cv0), 128'h0);

    // reset mid-operation with two entries queued
    core_ready = 1'b0;
    set_bank(1, 1'b1, 8'h11, 2'd1, 32'h1111);
    #1;
    tick();
    valid[1] = 1'b0;
    set_bank(2, 1'b1, 8'h22, 2'd2, 32'h2222);
    tick();
    valid[2] = 1'b0;
    chk("mid_count", 128'(dut.count_r), 128'h2);
    chk("mid_rr", 128'(dut.rr_ptr_r), 128'h3);
    set_bank(0, 1'b1, 8'h05, 2'd0, 32'h5);
    set_bank(2, 1'b1, 8'h06, 2'd2, 32'h6);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(cv0), 128'h0);
    chk("mid_rst_ready", 128'(ready0), 128'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_count", 128'(dut.count_r), 128'h0);
    chk("post_rst_rr", 128'(dut.rr_ptr_r), 128'h0);
    chk("post_rst_valid", 128'(cv0), 128'h0);
    chk("post_rst_ready", 128'(ready0), 128'h1);
    tick();
    chk("post_rst_head", 128'(tag0), 128'h05);
    chk("post_rst_count1", 128'(dut.count_r), 128'h1);

    // no-merge instance: banks 1 and 3 share a tag, rr_ptr=2
    valid = 4'b0000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    core_ready = 1'b1;
    set_bank(1, 1'b1, 8'h99, 2'd1, 32'h9001);
    #1;
    tick();
    set_bank(3, 1'b1, 8'h99, 2'd3, 32'h9003);
    #1;
    chk("id0_rr", 128'(u1.rr_ptr_r), 128'h2);
    chk("id0_ready_first", 128'(ready1), 128'h8);
    chk("id4_ready_merge", 128'(ready0), 128'hA);
    tick();
    valid[3] = 1'b0;
    chk("id0_tmask_first", 128'(tmask1), 128'h8);
    chk("id0_data_first", data1, 128'h00009003_00000000_00000000_00000000);
    #1;
    chk("id0_ready_second", 128'(ready1), 128'h2);
    tick();
    valid[1] = 1'b0;
    chk("id0_tmask_second", 128'(tmask1), 128'h2);
    chk("id0_tag_second", 128'(tag1), 128'h99);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
